wb_dma_copy: RTL and testbench
==============================

// Module: wb_dma_copy
//
// PURPOSE
//  Pipelined Wishbone bus master that copies a block of words from one bus
//  address to another, feeding the on-chip memory (and any other pipelined
//  Wishbone slave) directly. Works in chunks: a burst of reads into a local
//  buffer, then a burst of writes out of it. Sits upstream of the memory on
//  the bus, beside the CPU, behind the bus arbiter.
//
// PARAMETERS
//  AW     15  Wishbone word-address width
//  DW     32  Wishbone data width
//  LGBUF  4   log2 of local buffer depth in words (chunk size = 2**LGBUF)
//
// PORTS
//  i_clk       in   1       system clock
//  i_rst       in   1       asynchronous reset, active-high
//  i_start     in   1       one-cycle request to begin a copy; ignored while o_busy
//  i_src       in   AW      source word address, sampled with i_start
//  i_dst       in   AW      destination word address, sampled with i_start
//  i_len       in   AW+1    word count, 0..2**AW, sampled with i_start
//  o_busy      out  1       high from cycle after accepted i_start until o_done
//  o_done      out  1       one-cycle pulse at end of copy (success or error)
//  o_err       out  1       sticky bus-error flag; cleared by the next accepted i_start
//  o_wb_cyc    out  1       Wishbone cycle
//  o_wb_stb    out  1       Wishbone strobe
//  o_wb_we     out  1       Wishbone write enable (0 read phase, 1 write phase)
//  o_wb_addr   out  AW      Wishbone word address
//  o_wb_data   out  DW      Wishbone write data
//  i_wb_ack    in   1       Wishbone acknowledge
//  i_wb_stall  in   1       Wishbone stall
//  i_wb_err    in   1       Wishbone bus error
//  i_wb_data   in   DW      Wishbone read data
//
// BEHAVIOUR
//  - Reset (async, any time incl. mid-burst): all outputs 0, FSM to IDLE,
//    counters cleared; buffer contents undefined. No further bus activity.
//  - States: IDLE -> READ -> GAP -> WRITE -> GAP -> (READ | IDLE).
//  - IDLE: i_start latches src/dst/len, clears o_err. len==0: o_done
//    pulses next cycle, o_busy never rises, no cyc.
//  - Chunk size n = min(remaining, 2**LGBUF).
//  - READ: cyc=1, we=0; stb held until n requests accepted (accepted = stb &
//    !stall); address increments per accepted request. Each ack writes
//    i_wb_data into buffer[ack_count], ack_count increments. After n acks cyc
//    drops next edge. Acks may arrive back-to-back or spaced; no ack is lost.
//  - GAP: one cycle with cyc=0, stb=0 (releases arbiter between phases).
//  - WRITE: cyc=1, we=1; o_wb_data = buffer[req_count] for the request on the
//    bus; data/addr held stable while stalled. cyc drops after n acks.
//  - After WRITE: remaining -= n; src += n, dst += n. Remaining>0 -> GAP then
//    READ; else o_done pulses with the cycle cyc falls, o_busy falls same edge.
//  - Addresses wrap modulo 2**AW; no error on wrap.
//  - i_wb_err while cyc: cyc, stb drop next edge, outstanding acks abandoned,
//    o_err=1, o_done pulses, -> IDLE. i_wb_err with cyc=0 ignored.
//  - stb never asserted without cyc; requests outstanding never exceed n.
//  - Against a zero-stall, 1-cycle-ack slave: n-word read phase = n+1 cycles
//    with cyc high; throughput one word per clock per phase.
//
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/READ/GAP/WRITE) as localparams;
//    Wishbone field widths reused by bus masters.
//  - One sub-module: wb_dma_buf — 2**LGBUF x DW simple dual-port RAM,
//    write on ack in READ, combinational/registered read indexed by req_count
//    (registered read requires one-word lookahead; implementer's choice,
//    must meet WRITE timing above).
//  - Counters: remaining (AW+1), req_count/ack_count (LGBUF+1).
//
// TESTING  (bench: wb_dma_copy driving a 2**AW-word 1-cycle-ack memory model)
//  1. mem[0x10..0x14]=A0..A4; start src=0x10 dst=0x100 len=5 -> mem[0x100..0x104]
//     = A0..A4, one READ + one WRITE burst, o_done one pulse, o_err=0.
//  2. len=37, LGBUF=4 -> three chunks (16,16,5), GAP cycle between every phase,
//     destination matches source word-for-word.
//  3. Random i_wb_stall (50%) and ack delay 0-3 -> same result as 1; addr/data
//     stable while stalled; never more than 16 outstanding.
//  4. src=0x7FFE len=4 -> reads 0x7FFE,0x7FFF,0x0000,0x0001 (wrap).
//  5. i_wb_err on 3rd read ack -> cyc low next cycle, o_err=1, o_done pulse,
//     destination untouched; next start clears o_err.
//  6. len=0 -> o_done pulse, no cyc; i_rst mid-WRITE -> all outputs 0 at once.

Source files
------------

// File: rtl/wb_dma_copy_pkg.sv
// Shared definitions for the Wishbone block-copy master.
// Holds the bus field widths and the copy-engine FSM encoding.
package wb_dma_copy_pkg;

    localparam int WB_AW = 15;
    localparam int WB_DW = 32;

    localparam logic [1:0] DMA_IDLE  = 2'd0;
    localparam logic [1:0] DMA_READ  = 2'd1;
    localparam logic [1:0] DMA_GAP   = 2'd2;
    localparam logic [1:0] DMA_WRITE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = DMA_IDLE,
        ST_READ  = DMA_READ,
        ST_GAP   = DMA_GAP,
        ST_WRITE = DMA_WRITE
    } dma_state_t;

endpackage

// File: rtl/wb_dma_buf.sv
// Chunk buffer for the copy engine: one write port fed by read acks,
// one combinational read port indexed by the write-phase request counter.
module wb_dma_buf
    import wb_dma_copy_pkg::*;
#(
    parameter int DW    = WB_DW,
    parameter int LGBUF = 4
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [LGBUF-1:0] i_waddr,
    input  logic [DW-1:0]    i_wdata,
    input  logic [LGBUF-1:0] i_raddr,
    output logic [DW-1:0]    o_rdata
);

    logic [DW-1:0] mem [0:(1<<LGBUF)-1];

    // No reset: contents are only meaningful once a read phase has filled them.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/wb_dma_copy.sv
// Pipelined Wishbone master copying a block of words in chunks:
// a read burst into the local buffer, an idle gap, then a write burst out of it.
module wb_dma_copy
    import wb_dma_copy_pkg::*;
#(
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int LGBUF = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_src,
    input  logic [AW-1:0] i_dst,
    input  logic [AW:0]   i_len,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data
);

    localparam int BUF_WORDS = 1 << LGBUF;
    localparam logic [LGBUF:0] CNT_ONE = 1;

    // Bus handshake: a request is accepted on any edge where stb is high and
    // stall is low; each accepted request is answered by exactly one ack
    // (or the cycle is aborted by err). cyc stays high until the last ack.

    dma_state_t state, state_next;

    logic [AW-1:0]  src_addr, dst_addr, addr;
    logic [AW:0]    remaining;
    logic [LGBUF:0] chunk, req_count, ack_count;
    logic           gap_to_write, busy, done, err;
    logic           cyc, stb, we, accept, last_ack, last_chunk;
    logic [DW-1:0]  buf_rdata;

    function automatic logic [LGBUF:0] chunk_of(input logic [AW:0] words);
        if (words > (AW+1)'(BUF_WORDS)) begin
            return (LGBUF+1)'(BUF_WORDS);
        end
        return words[LGBUF:0];
    endfunction

    assign cyc        = (state == ST_READ) || (state == ST_WRITE);
    assign we         = (state == ST_WRITE);
    assign stb        = cyc && (req_count != chunk);
    assign accept     = stb && !i_wb_stall;
    assign last_ack   = i_wb_ack && ((ack_count + CNT_ONE) == chunk);
    assign last_chunk = (remaining == (AW+1)'(chunk));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_start && (i_len != '0)) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (i_wb_err) begin
                    state_next = ST_IDLE;
                end else if (last_ack) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                state_next = gap_to_write ? ST_WRITE : ST_READ;
            end
            ST_WRITE: begin
                if (i_wb_err) begin
                    state_next = ST_IDLE;
                end else if (last_ack) begin
                    state_next = last_chunk ? ST_IDLE : ST_GAP;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            src_addr     <= '0;
            dst_addr     <= '0;
            addr         <= '0;
            remaining    <= '0;
            chunk        <= '0;
            req_count    <= '0;
            ack_count    <= '0;
            gap_to_write <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        err <= 1'b0;
                        if (i_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            src_addr  <= i_src;
                            dst_addr  <= i_dst;
                            addr      <= i_src;
                            remaining <= i_len;
                            chunk     <= chunk_of(i_len);
                            req_count <= '0;
                            ack_count <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_to_write) begin
                        addr <= dst_addr;
                    end else begin
                        addr  <= src_addr;
                        chunk <= chunk_of(remaining);
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (i_wb_err) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else if (last_ack) begin
                        // Every request is already accepted here, so stb is low.
                        req_count    <= '0;
                        ack_count    <= '0;
                        gap_to_write <= (state == ST_READ);
                        if (state == ST_WRITE) begin
                            remaining <= remaining - (AW+1)'(chunk);
                            src_addr  <= src_addr + AW'(chunk);
                            dst_addr  <= dst_addr + AW'(chunk);
                            if (last_chunk) begin
                                done <= 1'b1;
                                busy <= 1'b0;
                            end
                        end
                    end else begin
                        if (accept) begin
                            addr      <= addr + AW'(1);
                            req_count <= req_count + CNT_ONE;
                        end
                        if (i_wb_ack) begin
                            ack_count <= ack_count + CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    wb_dma_buf #(
        .DW    (DW),
        .LGBUF (LGBUF)
    ) u_buf (
        .i_clk   (i_clk),
        .i_we    ((state == ST_READ) && i_wb_ack && !i_wb_err),
        .i_waddr (ack_count[LGBUF-1:0]),
        .i_wdata (i_wb_data),
        .i_raddr (req_count[LGBUF-1:0]),
        .o_rdata (buf_rdata)
    );

    assign o_busy    = busy;
    assign o_done    = done;
    assign o_err     = err;
    assign o_wb_cyc  = cyc;
    assign o_wb_stb  = stb;
    assign o_wb_we   = we;
    assign o_wb_addr = cyc ? addr : '0;
    assign o_wb_data = we ? buf_rdata : '0;

endmodule

// File: tb/tb_wb_dma_copy.sv
// Directed bench for wb_dma_copy against a 32K-word pipelined memory model
// with optional random stall, variable ack latency and error injection.
module tb_wb_dma_copy;

    logic        clk;
    logic        rst;
    logic        start;
    logic [14:0] src;
    logic [14:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err_o;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [14:0] wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_ack;
    logic        wb_stall;
    logic        wb_err;
    logic [31:0] wb_rdata;

    int checks;
    int failures;

    logic [31:0] mem [0:32767];

    wb_dma_copy #(.AW(15), .DW(32), .LGBUF(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_src      (src),
        .i_dst      (dst),
        .i_len      (len),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err_o),
        .o_wb_cyc   (wb_cyc),
        .o_wb_stb   (wb_stb),
        .o_wb_we    (wb_we),
        .o_wb_addr  (wb_addr),
        .o_wb_data  (wb_wdata),
        .i_wb_ack   (wb_ack),
        .i_wb_stall (wb_stall),
        .i_wb_err   (wb_err),
        .i_wb_data  (wb_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- memory slave model ----------------
    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } pend_t;

    pend_t       pq[$];
    int unsigned cyc_cnt;
    int unsigned rd_ack_num;
    int unsigned err_at;
    int unsigned max_delay;
    bit          stall_en;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
            wb_stall <= 1'b0;
            wb_rdata <= '0;
            pq.delete();
        end else begin
            cyc_cnt++;
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
            wb_stall <= stall_en ? ($urandom_range(0, 1) != 0) : 1'b0;
            if (!wb_cyc) begin
                pq.delete();
            end else begin
                if (wb_stb && !wb_stall) begin
                    pend_t p;
                    if (wb_we) mem[wb_addr] = wb_wdata;
                    p.data = mem[wb_addr];
                    p.due  = cyc_cnt + $urandom_range(0, max_delay);
                    pq.push_back(p);
                end
                if (pq.size() > 0 && pq[0].due <= cyc_cnt) begin
                    pend_t h;
                    h = pq.pop_front();
                    if (!wb_we) begin
                        rd_ack_num++;
                        if (rd_ack_num == err_at) begin
                            wb_err <= 1'b1;
                        end else begin
                            wb_ack   <= 1'b1;
                            wb_rdata <= h.data;
                        end
                    end else begin
                        wb_ack <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    int          cyc_cycles, rd_cyc_cycles, bursts, gap_cycles, done_cnt;
    int          stall_viol, proto_bad, err_resp_bad, outst, max_outst;
    logic [14:0] rd_addr_q[$];
    logic [14:0] prev_addr;
    logic [31:0] prev_data;
    bit          prev_ss, prev_cyc, err_pending;

    always @(posedge clk) begin
        if (!rst) begin
            if (wb_stb && !wb_cyc) proto_bad++;
            if (prev_ss && wb_cyc &&
                (wb_stb !== 1'b1 || wb_addr !== prev_addr || wb_wdata !== prev_data))
                stall_viol++;
            if (err_pending && wb_cyc) err_resp_bad++;
            err_pending = wb_cyc && wb_err;
            prev_ss   = wb_stb && wb_stall;
            prev_addr = wb_addr;
            prev_data = wb_wdata;
            if (wb_cyc) begin
                cyc_cycles++;
                if (!wb_we) rd_cyc_cycles++;
            end
            if (wb_cyc && !prev_cyc) bursts++;
            if (busy && !wb_cyc) gap_cycles++;
            if (done) done_cnt++;
            if (wb_stb && !wb_stall && !wb_we) rd_addr_q.push_back(wb_addr);
            if (!wb_cyc) outst = 0;
            else outst = outst + ((wb_stb && !wb_stall) ? 1 : 0) - (wb_ack ? 1 : 0);
            if (outst > max_outst) max_outst = outst;
            prev_cyc = wb_cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clr_stats();
        cyc_cycles = 0; rd_cyc_cycles = 0; bursts = 0; gap_cycles = 0;
        done_cnt = 0; stall_viol = 0; proto_bad = 0; err_resp_bad = 0;
        outst = 0; max_outst = 0; rd_ack_num = 0;
        rd_addr_q.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_copy(input logic [14:0] s, input logic [14:0] d, input logic [15:0] l);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (done !== 1'b1 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout done=%0b exp=1 after %0d cycles", name, done, i);
        end
    endtask

    task automatic fill(input int base, input int n, input logic [31:0] seed, input int step);
        for (int i = 0; i < n; i++) mem[(base + i) & 32'h7FFF] = seed + step * i;
    endtask

    task automatic check_block(input string name, input int base, input int n,
                               input logic [31:0] seed, input int step);
        for (int i = 0; i < n; i++) begin
            logic [31:0] exp_w;
            exp_w = seed + step * i;
            checks++;
            if (mem[(base + i) & 32'h7FFF] !== exp_w) begin
                failures++;
                $display("FAIL %s_word[%0d] got=%h exp=%h", name, i, mem[(base + i) & 32'h7FFF], exp_w);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        stall_en = 1'b0; max_delay = 0; err_at = 0;
        clr_stats();
        settle(2);
        checks++;
        if ({wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, busy, done, err_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0b stb=%0b busy=%0b done=%0b err=%0b exp=all 0",
                     wb_cyc, wb_stb, busy, done, err_o);
        end
        rst = 1'b0;
        settle(2);
    endtask

    task automatic test_basic();
        clr_stats();
        fill(32'h10, 5, 32'hA0, 1);
        fill(32'h100, 6, 32'hDEAD_0000, 1);
        start_copy(15'h10, 15'h100, 16'd5);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        wait_done("basic");
        settle(3);
        check_block("basic", 32'h100, 5, 32'hA0, 1);
        check_block("basic_tail", 32'h105, 1, 32'hDEAD_0005, 0);
        checks++;
        if (rd_cyc_cycles != 6) begin failures++; $display("FAIL basic_read_cycles got=%0d exp=6", rd_cyc_cycles); end
        checks++;
        if (cyc_cycles != 12) begin failures++; $display("FAIL basic_cyc_cycles got=%0d exp=12", cyc_cycles); end
        checks++;
        if (bursts != 2 || gap_cycles != 1) begin
            failures++; $display("FAIL basic_bursts got=%0d/%0d exp=2/1", bursts, gap_cycles);
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
        checks++;
        if (err_o !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_flags err=%0b busy=%0b exp=0/0", err_o, busy);
        end
    endtask

    task automatic test_chunks();
        clr_stats();
        fill(32'h800, 37, 32'hC000_0000, 3);
        fill(32'h1000, 38, 32'h0BAD_0000, 0);
        start_copy(15'h800, 15'h1000, 16'd37);
        wait_done("chunks");
        settle(3);
        check_block("chunks", 32'h1000, 37, 32'hC000_0000, 3);
        check_block("chunks_tail", 32'h1025, 1, 32'h0BAD_0000, 0);
        checks++;
        if (bursts != 6 || gap_cycles != 5) begin
            failures++; $display("FAIL chunks_bursts got=%0d/%0d exp=6/5", bursts, gap_cycles);
        end
        checks++;
        if (rd_cyc_cycles != 40) begin failures++; $display("FAIL chunks_read_cycles got=%0d exp=40", rd_cyc_cycles); end
        checks++;
        if (max_outst > 16) begin failures++; $display("FAIL chunks_outstanding got=%0d exp<=16", max_outst); end
    endtask

    task automatic test_stall();
        stall_en = 1'b1; max_delay = 3;
        clr_stats();
        fill(32'h140, 5, 32'h0, 0);
        start_copy(15'h10, 15'h140, 16'd5);
        wait_done("stall5");
        settle(3);
        check_block("stall5", 32'h140, 5, 32'hA0, 1);
        clr_stats();
        fill(32'h900, 37, 32'h3000_0000, 7);
        start_copy(15'h900, 15'h1800, 16'd37);
        wait_done("stall37");
        settle(3);
        check_block("stall37", 32'h1800, 37, 32'h3000_0000, 7);
        checks++;
        if (stall_viol != 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stall_viol); end
        checks++;
        if (max_outst > 16 || max_outst < 1) begin
            failures++; $display("FAIL stall_outstanding got=%0d exp=1..16", max_outst);
        end
        checks++;
        if (proto_bad != 0 || done_cnt != 1) begin
            failures++; $display("FAIL stall_protocol stb_no_cyc=%0d done=%0d exp=0/1", proto_bad, done_cnt);
        end
        stall_en = 1'b0; max_delay = 0;
        settle(2);
    endtask

    task automatic test_wrap();
        logic [14:0] exp_a [4];
        exp_a = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
        clr_stats();
        fill(32'h7FFE, 4, 32'h7700_0000, 5);
        start_copy(15'h7FFE, 15'h200, 16'd4);
        wait_done("wrap");
        settle(3);
        check_block("wrap", 32'h200, 4, 32'h7700_0000, 5);
        checks++;
        if (rd_addr_q.size() != 4) begin
            failures++; $display("FAIL wrap_read_count got=%0d exp=4", rd_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_addr_q[i] !== exp_a[i]) begin
                    failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, rd_addr_q[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_error();
        clr_stats();
        err_at = 3;
        fill(32'h300, 8, 32'h1234_0000, 1);
        fill(32'h400, 8, 32'h5555_0000, 1);
        start_copy(15'h300, 15'h400, 16'd8);
        wait_done("error");
        settle(3);
        checks++;
        if (err_o !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL error_flags err=%0b busy=%0b exp=1/0", err_o, busy);
        end
        checks++;
        if (err_resp_bad != 0 || bursts != 1) begin
            failures++; $display("FAIL error_abort late_cyc=%0d bursts=%0d exp=0/1", err_resp_bad, bursts);
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL error_done_pulses got=%0d exp=1", done_cnt); end
        check_block("error_dst", 32'h400, 8, 32'h5555_0000, 1);
        err_at = 0;
        clr_stats();
        start_copy(15'h300, 15'h500, 16'd2);
        checks++;
        if (err_o !== 1'b0) begin failures++; $display("FAIL error_clear got=%0b exp=0", err_o); end
        wait_done("error_retry");
        settle(3);
        check_block("error_retry", 32'h500, 2, 32'h1234_0000, 1);
    endtask

    task automatic test_len0_and_reset();
        int b;
        int i;
        clr_stats();
        start_copy(15'h10, 15'h600, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL len0_done done=%0b busy=%0b exp=1/0", done, busy);
        end
        settle(4);
        checks++;
        if (bursts != 0 || done_cnt != 1) begin
            failures++; $display("FAIL len0_bus bursts=%0d done=%0d exp=0/1", bursts, done_cnt);
        end
        clr_stats();
        start_copy(15'h10, 15'h640, 16'd20);
        i = 0;
        while (!(wb_cyc && wb_we) && i < 500) begin @(negedge clk); i++; end
        checks++;
        if (!(wb_cyc && wb_we)) begin failures++; $display("FAIL rst_reach_write cyc=%0b we=%0b exp=1/1", wb_cyc, wb_we); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, busy, done, err_o} !== '0) begin
            failures++;
            $display("FAIL rst_async cyc=%0b stb=%0b we=%0b addr=%h busy=%0b exp=all 0",
                     wb_cyc, wb_stb, wb_we, wb_addr, busy);
        end
        settle(2);
        rst = 1'b0;
        b = bursts;
        settle(5);
        checks++;
        if (bursts != b || busy !== 1'b0) begin
            failures++; $display("FAIL rst_quiet bursts=%0d busy=%0b exp=%0d/0", bursts, busy, b);
        end
        clr_stats();
        start_copy(15'h10, 15'h700, 16'd3);
        wait_done("rst_recover");
        settle(3);
        check_block("rst_recover", 32'h700, 3, 32'hA0, 1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc_cnt = 0;
        test_reset();
        test_basic();
        test_chunks();
        test_stall();
        test_wrap();
        test_error();
        test_len0_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
